// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// default width, funct3 encodings, FSM states and funct3 decode helpers.
package muldiv_unit_pkg;

  // Operand and result width used when the unit is not overridden
  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Upper half of the funct3 space is the divide/remainder family
  function automatic logic f3_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Remainder forms return the remainder half of the divider
  function automatic logic f3_is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  // rs1 is interpreted as signed for these operations
  function automatic logic f3_signed_a(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  // rs2 is interpreted as signed for these operations
  function automatic logic f3_signed_b(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fixup.sv
// Combinational sign handling around the unsigned iterative core:
// produces operand magnitudes, then applies the final negation and
// the divide-by-zero / signed-overflow result selection.
module sign_fixup
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_opA,
  input  logic [XLEN-1:0]   i_opB,
  input  logic [2*XLEN-1:0] i_rawAcc,
  output logic [XLEN-1:0]   o_absA,
  output logic [XLEN-1:0]   o_absB,
  output logic [XLEN-1:0]   o_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              w_negA;
  logic              w_negB;
  logic              w_isDiv;
  logic              w_isRem;
  logic              w_divZero;
  logic              w_overflow;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quotRaw;
  logic [XLEN-1:0]   w_remRaw;

  assign w_negA     = f3_signed_a(i_funct3) && i_opA[XLEN-1];
  assign w_negB     = f3_signed_b(i_funct3) && i_opB[XLEN-1];
  assign w_isDiv    = f3_is_div(i_funct3);
  assign w_isRem    = f3_is_rem(i_funct3);
  assign o_absA     = w_negA ? -i_opA : i_opA;
  assign o_absB     = w_negB ? -i_opB : i_opB;
  assign w_divZero  = (i_opB == '0);
  assign w_overflow = f3_signed_b(i_funct3) && (i_opA == MIN_NEG) && (i_opB == '1);

  assign w_prod    = (w_negA ^ w_negB) ? -i_rawAcc : i_rawAcc;
  assign w_quotRaw = i_rawAcc[XLEN-1:0];
  assign w_remRaw  = i_rawAcc[2*XLEN-1:XLEN];

  // Pick the architectural result: product half, special case, or signed quotient/remainder
  always_comb begin
    o_result = '0;
    if (!w_isDiv) begin
      if (i_funct3 == F3_MUL) o_result = w_prod[XLEN-1:0];
      else                    o_result = w_prod[2*XLEN-1:XLEN];
    end else if (w_divZero) begin
      o_result = w_isRem ? i_opA : '1;
    end else if (w_overflow) begin
      o_result = w_isRem ? '0 : MIN_NEG;
    end else if (w_isRem) begin
      o_result = w_negA ? -w_remRaw : w_remRaw;
    end else begin
      o_result = (w_negA ^ w_negB) ? -w_quotRaw : w_quotRaw;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, fixed XLEN-cycle latency, registered
// write-back to the register file with a one-cycle done pulse.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            r,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic [4:0]      rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut,
  output logic            writeEn
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  state_e            r_state;
  state_e            w_stateNext;
  logic [XLEN-1:0]   r_opA;
  logic [XLEN-1:0]   r_opB;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rdOut;
  logic              r_writeEn;

  logic              w_accept;
  logic              w_lastIter;
  logic              w_isDiv;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [2*XLEN-1:0] w_accCur;
  logic [2*XLEN-1:0] w_accNext;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_divShift;
  logic [XLEN-1:0]   w_divDiff;
  logic              w_divGe;
  logic [XLEN-1:0]   w_fixed;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_lastIter = (r_state == ST_CALC) && (r_count == LAST_ITER);
  assign w_isDiv    = f3_is_div(r_funct3);

  assign result  = r_result;
  assign rdOut   = r_rdOut;
  assign writeEn = r_writeEn;

  sign_fixup #(.XLEN(XLEN)) u_sign_fixup (
    .i_funct3 (r_funct3),
    .i_opA    (r_opA),
    .i_opB    (r_opB),
    .i_rawAcc (w_accNext),
    .o_absA   (w_absA),
    .o_absB   (w_absB),
    .o_result (w_fixed)
  );

  // One iteration step; the first step seeds the accumulator from the magnitudes
  always_comb begin
    w_accCur = r_acc;
    if (r_count == '0) begin
      w_accCur = w_isDiv ? {{XLEN{1'b0}}, w_absA} : {{XLEN{1'b0}}, w_absB};
    end
    w_mulSum   = {1'b0, w_accCur[2*XLEN-1:XLEN]} + (w_accCur[0] ? {1'b0, w_absA} : '0);
    w_divShift = {w_accCur[2*XLEN-1:XLEN], w_accCur[XLEN-1]};
    w_divGe    = (w_divShift >= {1'b0, w_absB});
    w_divDiff  = w_divShift[XLEN-1:0] - w_absB;
    w_accNext  = {w_mulSum, w_accCur[XLEN-1:1]};
    if (w_isDiv) begin
      if (w_divGe) w_accNext = {w_divDiff, w_accCur[XLEN-2:0], 1'b1};
      else         w_accNext = {w_divShift[XLEN-1:0], w_accCur[XLEN-2:0], 1'b0};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge r) begin
    if (!r) r_state <= ST_IDLE;
    else    r_state <= w_stateNext;
  end

  // FSM next-state and status outputs
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_stateNext = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (r_count == LAST_ITER) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered write-back
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_opA     <= '0;
      r_opB     <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_rdOut   <= '0;
      r_writeEn <= 1'b0;
    end else begin
      r_writeEn <= 1'b0;
      if (w_accept) begin
        r_opA    <= dataA;
        r_opB    <= dataB;
        r_funct3 <= funct3;
        r_rd     <= rdIn;
        r_count  <= '0;
        r_acc    <= '0;
      end else if (r_state == ST_CALC) begin
        r_acc   <= w_accNext;
        r_count <= r_count + CW'(1);
        if (w_lastIter) begin
          r_result  <= w_fixed;
          r_rdOut   <= r_rd;
          r_writeEn <= (r_rd != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner vectors,
// randomized operations against a plain-arithmetic reference model,
// write suppression, start-ignore while busy, and mid-operation reset.
module tb_muldiv_unit;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        r;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  rdIn;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;
  logic        writeEn;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .r       (r),
    .start   (start),
    .funct3  (funct3),
    .dataA   (dataA),
    .dataB   (dataB),
    .rdIn    (rdIn),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rdOut   (rdOut),
    .writeEn (writeEn)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M reference computed with 64-bit host arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and observe its completion (bounded wait)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output logic we, output int lat, output logic earlyWe, output logic doneNext);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    dataA  = a;
    dataB  = b;
    rdIn   = rd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    dataA   = $urandom;
    dataB   = $urandom;
    rdIn    = 5'($urandom);
    funct3  = 3'($urandom);
    lat     = 0;
    earlyWe = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && writeEn) earlyWe = 1'b1;
    end while (!done && lat < 100);
    res = result;
    rdo = rdOut;
    we  = writeEn;
    @(posedge clk);
    #1;
    doneNext = done | writeEn;
  endtask

  task automatic test_reset();
    r = 1'b0;
    start = 1'b0;
    funct3 = 3'd0;
    dataA = 32'd0;
    dataB = 32'd0;
    rdIn = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (writeEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_writeEn: got %b expected 0", writeEn); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (rdOut !== 5'd0) begin errors++; $display("[TB] FAIL reset_rdOut: got %0d expected 0", rdOut); end
    #1 r = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs [11] = '{
      '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
      '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000},
      '{3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF},
      '{3'b111, 32'd100,        32'd0,         32'h0000_0064},
      '{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB}
    };
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        we;
    logic        earlyWe;
    logic        doneNext;
    int          lat;
    logic [4:0]  rd;
    for (int i = 0; i < 11; i++) begin
      rd = 5'($urandom_range(1, 31));
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, rd, res, rdo, we, lat, earlyWe, doneNext);
      checks++; if (res !== vecs[i].exp) begin errors++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].exp); end
      checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d expected 32", i, lat); end
      checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_writeEn: got %b expected 1", i, we); end
      checks++; if (rdo !== rd) begin errors++; $display("[TB] FAIL dir%0d_rdOut: got %0d expected %0d", i, rdo, rd); end
      checks++; if (earlyWe !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_early_write: got %b expected 0", i, earlyWe); end
      checks++; if (doneNext !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_width: got %b expected 0", i, doneNext); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] exp;
    logic [4:0]  rdo;
    logic        we;
    logic        earlyWe;
    logic        doneNext;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = rand_operand();
      b   = rand_operand();
      rd  = 5'($urandom_range(0, 31));
      exp = model(f, a, b);
      run_op(f, a, b, rd, res, rdo, we, lat, earlyWe, doneNext);
      checks++; if (res !== exp) begin errors++; $display("[TB] FAIL rnd%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
      checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL rnd%0d_latency: got %0d expected 32", i, lat); end
      checks++; if (we !== (rd != 5'd0)) begin errors++; $display("[TB] FAIL rnd%0d_writeEn: got %b expected %b", i, we, (rd != 5'd0)); end
      checks++; if (rdo !== rd) begin errors++; $display("[TB] FAIL rnd%0d_rdOut: got %0d expected %0d", i, rdo, rd); end
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        we;
    logic        earlyWe;
    logic        doneNext;
    int          lat;
    run_op(3'b000, 32'd5, 32'd6, 5'd0, res, rdo, we, lat, earlyWe, doneNext);
    checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL rd0_done_latency: got %0d expected 32", lat); end
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL rd0_writeEn: got %b expected 0", we); end
    checks++; if (earlyWe !== 1'b0) begin errors++; $display("[TB] FAIL rd0_early_write: got %b expected 0", earlyWe); end
    checks++; if (res !== 32'd30) begin errors++; $display("[TB] FAIL rd0_result: got %h expected 0000001e", res); end
  endtask

  task automatic test_back_to_back();
    int          edgeIdx;
    int          doneCount;
    int          firstDone;
    logic [31:0] firstRes;
    logic [4:0]  firstRd;
    logic [31:0] exp;
    exp       = model(3'b101, 32'd1000, 32'd7);
    doneCount = 0;
    firstDone = -1;
    firstRes  = 32'd0;
    firstRd   = 5'd0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; dataA = 32'd1000; dataB = 32'd7; rdIn = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    edgeIdx = 0;
    repeat (5) begin @(posedge clk); edgeIdx++; end
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; dataA = 32'd2; dataB = 32'd3; rdIn = 5'd4;
    @(posedge clk);
    edgeIdx++;
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      edgeIdx++;
      if (done) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = edgeIdx;
          firstRes  = result;
          firstRd   = rdOut;
        end
      end
    end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount); end
    checks++; if (firstDone !== 32) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 32", firstDone); end
    checks++; if (firstRes !== exp) begin errors++; $display("[TB] FAIL b2b_result: got %h expected %h", firstRes, exp); end
    checks++; if (firstRd !== 5'd9) begin errors++; $display("[TB] FAIL b2b_rdOut: got %0d expected 9", firstRd); end
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        we;
    logic        earlyWe;
    logic        doneNext;
    int          lat;
    run_op(3'b000, 32'd3, 32'd5, 5'd7, res, rdo, we, lat, earlyWe, doneNext);
    checks++; if (res !== 32'd15) begin errors++; $display("[TB] FAIL pre_reset_result: got %h expected 0000000f", res); end
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; dataA = $urandom; dataB = 32'd3; rdIn = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midcalc_busy: got %b expected 1", busy); end
    #1 r = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL async_done: got %b expected 0", done); end
    checks++; if (writeEn !== 1'b0) begin errors++; $display("[TB] FAIL async_writeEn: got %b expected 0", writeEn); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL async_result: got %h expected 00000000", result); end
    checks++; if (rdOut !== 5'd0) begin errors++; $display("[TB] FAIL async_rdOut: got %0d expected 0", rdOut); end
    repeat (3) @(posedge clk);
    #2 r = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, 5'd11, res, rdo, we, lat, earlyWe, doneNext);
    checks++; if (res !== 32'h0000_000C) begin errors++; $display("[TB] FAIL post_reset_result: got %h expected 0000000c", res); end
    checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 32", lat); end
    checks++; if (earlyWe !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_stale_write: got %b expected 0", earlyWe); end
    checks++; if (rdo !== 5'd11) begin errors++; $display("[TB] FAIL post_reset_rdOut: got %0d expected 11", rdo); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_directed();
    test_rd_zero();
    test_random();
    test_back_to_back();
    test_reset_midcalc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
